// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex font and special segment codes.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  // Bits 6:0 are segments g..a, active high.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_font.sv
// Combinational hex-nibble to 7-segment pattern lookup.
module seg_font
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] font_o
);

  assign font_o = SEG_FONT[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-cathode 7-segment scanner with frame-aligned shadow registers.
// Optional blink support is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*4-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_q, pend_d;
  logic [DIGITS*4-1:0] data_sh_q;
  logic [DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                ft_q, ft_d;

  logic                cnt_wrap, frame_wrap, boundary;
  logic                blink_off, suppress;
  logic [IW-1:0]       hi_nz;
  logic [3:0]          nib;
  logic [6:0]          font;

  assign cnt_wrap   = (cnt_q == CW'(SCAN_DIV - 1));
  assign frame_wrap = cnt_wrap && (idx_q == IW'(DIGITS - 1));
  // A load arriving exactly at the boundary is honoured there instead of waiting a frame.
  assign boundary   = frame_wrap && (pend_q || load);

  always_comb begin
    cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (cnt_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    pend_d = boundary ? 1'b0 : (pend_q || load);
  end

  // Highest nonzero shadow digit; digit 0 is the floor so it is never suppressed.
  always_comb begin
    hi_nz = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (data_sh_q[4*i +: 4] != 4'h0) hi_nz = IW'(i);
    end
  end

  assign nib      = data_sh_q[{idx_q, 2'b00} +: 4];
  assign suppress = lz_en && (idx_q > hi_nz);

  seg_font u_font (
    .nib_i  (nib),
    .font_o (font)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] bcnt_q;
  logic          phase_off_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q      <= '0;
      phase_off_q <= 1'b0;
    end else if (frame_wrap) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_q      <= '0;
        phase_off_q <= ~phase_off_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  assign blink_off = phase_off_q && blink_mask[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '0;
    ft_d  = (cnt_q == '0) && (idx_q == '0);
    if (cnt_q >= CW'(DEAD)) begin
      an_d = DIGITS'(1) << idx_q;
      if (blank_sh_q[idx_q] || blink_off) seg_d = SEG_BLANK;
      else if (suppress)                  seg_d = dp_sh_q[idx_q] ? SEG_DP : SEG_BLANK;
      else                                seg_d = {dp_sh_q[idx_q], font};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= '0;
      ft_q       <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      if (boundary) begin
        data_sh_q  <= digit_data;
        dp_sh_q    <= dp;
        blank_sh_q <= blank;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      ft_q  <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a bank of common-cathode 7-segment digits. It latches a frame of per-digit hex nibbles, decimal-point flags and blank flags, then scans one digit at a time with a programmable slot length and a dead interval to suppress ghosting. It sits between the datapath that produces display values and the board's segment/anode pins, replacing per-digit static decoders.

## Interface
- `DIGITS`, 8: number of digits scanned; legal range 2..16.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be at least 2.
- `DEAD`, 500: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ DEAD < SCAN_DIV.
- `BLINK_FRAMES`, 64: frames per blink half-period; only used when blink is compiled in.

- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `digit_data`  in  DIGITS*4: nibble i in bits [4i+3:4i]; digit DIGITS-1 is the most significant.
- `dp`  in  DIGITS: decimal-point enable per digit.
- `blank`  in  DIGITS: force a digit dark, including its dp.
- `lz_en`  in  1: leading-zero suppression enable.
- `load`  in  1: request a shadow update at the next frame boundary.
- `blink_mask`  in  DIGITS: digits that blink. The port always exists and is ignored without the macro.
- `seg`  out  8: active-high segments; bit 7 is dp, bits 6:0 are g..a. The font is 0→0x3f, 1→0x06, … F→0x71.
- `an`  out  DIGITS: one-hot active-high digit enable; all zero when no digit is lit.
- `frame_tick`  out  1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Prescaler.** `cnt` counts 0..SCAN_DIV-1. At the terminal count it returns to 0 and `idx` advances. `idx` wraps from DIGITS-1 to 0.
- **Shadow registers.** `digit_data`, `dp` and `blank` are captured into shadow registers only at a frame boundary: the cycle in which `idx` wraps to 0 while `pend` is set.
  - `load` sets `pend`. The shadow update clears it.
  - If `load` and a boundary occur in the same cycle, the update happens at that boundary using the current inputs, and `pend` ends up clear.
  - Repeated `load` pulses before a boundary collapse into one update.
  - `blink_mask` and `lz_en` are sampled live, not shadowed.
- **Leading-zero suppression.** When `lz_en` is high, digits from DIGITS-1 down to the highest nonzero shadow digit, exclusive, are blanked. Digit 0 is never suppressed. A dp on a suppressed digit is still shown, with `seg` = 0x80.
- **Digit output.** For the current `idx`, `seg` = font(nibble) | (dp<<7).
  - `seg` = 0x00 if the shadow blank flag is set.
  - `seg` = 0x00 during a blink-off phase for a digit in `blink_mask`.
- **Anodes.** `an` = 0 while `cnt` < DEAD, and one-hot(`idx`) otherwise.
- **Dead interval.** `seg` is forced to 0x00 whenever `an` is 0.

## Timing
- `seg`, `an` and `frame_tick` are registered. They reflect the `cnt`/`idx` state of the preceding cycle, so latency is 1 cycle.
- Reset values: `cnt`=0, `idx`=0, `pend`=0, shadows=0, blink phase=on, blink counter=0, `seg`=0x00, `an`=0, `frame_tick`=0.
- **After reset release.** Slot 0 begins. `an` first becomes one-hot(0) on the (DEAD+1)th rising edge.
- **Per slot.** Each slot keeps `an` dark for exactly DEAD cycles and lit for SCAN_DIV−DEAD cycles. A frame is DIGITS*SCAN_DIV cycles.
- **Frame tick.** `frame_tick` is high for exactly one cycle per frame, aligned with the first output cycle of digit 0's slot.
- **Reset mid-scan.** Outputs clear immediately (asynchronously), and any pending load is discarded.
- **Shadow visibility.** A shadow update is visible in `seg` starting with digit 0 of the new frame. No frame ever mixes old and new data.

## Configuration
- **`SEG_SCAN_BLINK_EN` defined:** a frame counter toggles the blink phase every BLINK_FRAMES frames. During the off phase, digits in `blink_mask` output `seg`=0x00; `an` still scans normally.
- **Not defined:** no blink counter is built, `blink_mask` is unused, and all digits are always displayed.

## Structure
- Package `seg_pkg` contains:
  - the 16-entry font constant array;
  - `SEG_BLANK` (8'h00);
  - `SEG_DP` (8'h80).
- Sub-module `seg_font`: combinational nibble → 7-bit font lookup from the package, instantiated once on the selected digit.
- The prescaler width is $clog2(SCAN_DIV) and the index width is $clog2(DIGITS).

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, DEAD=1.
- **Reset, then scan.** Expect `an` = 0000 for 1 cycle, then 0001 for 3 cycles, then 0000, then 0010, and so on. `frame_tick` pulses every 16 cycles.
- **Load mid-frame.** Drive `digit_data`=16'h1234 and pulse `load` during digit 2's slot. Digits 2 and 3 still show the old values. The next frame shows `seg` 0x66, 0x4f, 0x5b, 0x06 for digits 0..3.
- **Leading-zero suppression with dp.** `digit_data`=16'h0005, `lz_en`=1, `dp`=4'b0100. Expect digit 0 = 0x6d, digit 1 = 0x00, digit 2 = 0x80, digit 3 = 0x00. With `digit_data`=16'h0000, digit 0 shows 0x3f.
- **Blank flag.** `blank`=4'b0001 with `digit_data`=16'h8888. Expect digit 0 `seg` = 0x00 while `an`=0001; the other digits show 0x7f.
- **Reset mid-slot.** Assert `rst` mid-slot, pulse `load` before release. Expect `seg`/`an` = 0 immediately, and no shadow update at the next boundary.
- **Blink (macro on, BLINK_FRAMES=2).** `blink_mask`=4'b0010. Digit 1 shows 0x00 in frames 2–3 and its font value in frames 0–1 and 4–5.
